generic_bus_mem_responder: RTL and testbench



---
 rtl/bus_responder_pkg.sv | 23 ++
 rtl/generic_bus_if.sv | 20 ++
 rtl/bus_responder_ram.sv | 56 +++++
 rtl/generic_bus_mem_responder.sv | 130 +++++++++++++
 tb/tb_generic_bus_mem_responder.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_responder_pkg.sv
// Shared types and helpers for the generic-bus memory responder.
package bus_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int LAT_W = 4;

  // Out-of-window addresses wrap silently; the byte offset bits are dropped.
  function automatic logic [31:0] word_index(
    input logic [31:0] addr,
    input logic [31:0] base_addr,
    input int unsigned depth
  );
    logic [31:0] offset;
    offset = addr - base_addr;
    return (offset >> 2) & (depth - 1);
  endfunction

endpackage

// File: rtl/generic_bus_if.sv
// Request/response bus between pipeline stages and a memory responder.
interface generic_bus_if;
  logic        ren;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic [31:0] rdata;
  logic        busy;

  modport generic_bus (
    input  ren, wen, addr, wdata, byte_en,
    output rdata, busy
  );

  modport cpu (
    output ren, wen, addr, wdata, byte_en,
    input  rdata, busy
  );
endinterface

// File: rtl/bus_responder_ram.sv
// DEPTH x 32 RAM with byte write enables and a registered, write-first read port.
module bus_responder_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  always_ff @(posedge CLK) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read data only moves on a read strobe, so the port holds its last word.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
      if (we_i && (waddr_i == raddr_i)) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) begin
            rdata_d[8*b +: 8] = wdata_i[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/generic_bus_mem_responder.sv
// Memory responder on generic_bus_if: fixed-latency wait-state FSM in front of
// a byte-writable RAM; busy drops for exactly one cycle per completed access.
module generic_bus_mem_responder
  import bus_responder_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  nRST,
  generic_bus_if.generic_bus    gen_bus_if
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'(LATENCY - 1);
  localparam logic [LAT_W-1:0] CNT_ONE  = LAT_W'(1);

  state_t           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             is_wr_q, is_wr_d;

  logic             req;
  logic [AW-1:0]    live_idx;
  logic             commit;
  logic             use_live;
  logic             ram_we;
  logic             ram_re;
  logic [AW-1:0]    ram_idx;
  logic [31:0]      ram_wdata;
  logic [3:0]       ram_be;
  logic [31:0]      ram_rdata;

  assign req      = gen_bus_if.ren | gen_bus_if.wen;
  assign live_idx = AW'(word_index(gen_bus_if.addr, BASE_ADDR, DEPTH));

  // commit marks the edge that enters RESP; with LATENCY == 1 that is the
  // accept edge itself, so the live bus values feed the RAM directly.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    is_wr_d  = is_wr_q;
    commit   = 1'b0;
    use_live = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = live_idx;
          wdata_d = gen_bus_if.wdata;
          be_d    = gen_bus_if.byte_en;
          is_wr_d = gen_bus_if.wen;
          cnt_d   = CNT_INIT;
          if (LATENCY == 1) begin
            state_d  = RESP;
            commit   = 1'b1;
            use_live = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = RESP;
            commit  = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      is_wr_q <= is_wr_d;
    end
  end

  assign ram_idx   = use_live ? live_idx           : idx_q;
  assign ram_wdata = use_live ? gen_bus_if.wdata   : wdata_q;
  assign ram_be    = use_live ? gen_bus_if.byte_en : be_q;
  assign ram_we    = commit & (use_live ? gen_bus_if.wen : is_wr_q);
  assign ram_re    = commit & ~ram_we;

  bus_responder_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .CLK     (CLK),
    .nRST    (nRST),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .waddr_i (ram_idx),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_idx),
    .rdata_o (ram_rdata)
  );

  assign gen_bus_if.rdata = ram_rdata;
  assign gen_bus_if.busy  = (state_q != RESP);

endmodule

// File: tb/tb_generic_bus_mem_responder.sv
// Four responders (LATENCY 1,3,4,5; DEPTH 16) driven by directed then random
// traffic; a per-instance monitor checks response timing and data from a queue.
module tb_generic_bus_mem_responder;

  typedef struct {
    bit          rd;
    bit          wr;
    bit          abort;
    bit          hold;
    logic [31:0] off;
    logic [31:0] wd;
    logic [3:0]  be;
  } op_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          is_rd;
  } exp_t;

  localparam int N_DIR = 29;
  localparam int N_RND = 200;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic op_t dir_op(input int i);
    op_t o;
    o.rd = 1'b0; o.wr = 1'b1; o.abort = 1'b0; o.hold = 1'b0;
    o.off = 32'(i * 4); o.wd = 32'h0; o.be = 4'hF;
    case (i)
      16: begin o.off = 32'h10; o.wd = 32'hDEADBEEF; o.be = 4'hF; end
      17: begin o.rd = 1; o.wr = 0; o.off = 32'h10; o.be = 4'h0; end
      18: begin o.off = 32'h10; o.wd = 32'h0000AA00; o.be = 4'b0010; end
      19: begin o.rd = 1; o.wr = 0; o.off = 32'h10; o.be = 4'h0; end
      20: begin o.off = 32'h10; o.wd = 32'h12340000; o.be = 4'b1100; end
      21: begin o.rd = 1; o.wr = 0; o.off = 32'h10; end
      22: begin o.off = 32'h40; o.wd = 32'hCAFEF00D; end
      23: begin o.rd = 1; o.wr = 0; o.off = 32'h0; end
      24: begin o.off = 32'h30; o.wd = 32'h55; o.abort = 1; end
      25: begin o.rd = 1; o.wr = 0; o.off = 32'h30; end
      26, 27, 28: begin o.rd = 1; o.wr = 0; o.off = 32'h20; o.hold = 1; end
      default: ;
    endcase
    return o;
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_inst
    localparam int          L    = (gi == 0) ? 1 : (gi == 1) ? 3 : (gi == 2) ? 4 : 5;
    localparam logic [31:0] BASE = (gi == 2) ? 32'h0000_1000 : 32'h0000_0000;

    generic_bus_if bus();
    logic rst_n;

    generic_bus_mem_responder #(
      .DEPTH     (16),
      .LATENCY   (L),
      .BASE_ADDR (BASE)
    ) dut (
      .CLK        (clk),
      .nRST       (rst_n),
      .gen_bus_if (bus)
    );

    exp_t        q[$];
    exp_t        e;
    logic [31:0] mem [16];
    logic [31:0] last_rd;

    always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.busy === 1'b0) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL inst%0d unexpected_resp: busy low at cycle %0d, nothing pending", gi, cyc);
        end else begin
          e = q.pop_front();
          n_cmp++;
          if (cyc != e.cyc) begin
            n_bad++;
            $display("FAIL inst%0d resp_cycle: got %0d required %0d", gi, cyc, e.cyc);
          end
          n_cmp++;
          if (bus.rdata !== e.data) begin
            n_bad++;
            $display("FAIL inst%0d rdata: got %h required %h", gi, bus.rdata, e.data);
          end
          $display("inst%0d L=%0d %s resp cycle %0d rdata %h", gi, L, e.is_rd ? "rd" : "wr",
                   cyc, bus.rdata);
        end
      end
    end

    initial begin
      op_t op;
      int  n, j, k, idx;
      bit  chained, do_rst;
      rst_n = 1'b1;
      bus.ren = 0; bus.wen = 0; bus.addr = 0; bus.wdata = 0; bus.byte_en = 0;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b1) begin
        n_bad++; $display("FAIL inst%0d reset_busy: got %b required 1", gi, bus.busy);
      end
      n_cmp++;
      if (bus.rdata !== 32'h0) begin
        n_bad++; $display("FAIL inst%0d reset_rdata: got %h required 0", gi, bus.rdata);
      end
      rst_n = 1'b1;
      last_rd = 32'h0;
      chained = 0;

      for (int t = 0; t < N_DIR + N_RND; t++) begin
        do_rst = 0;
        if (t < N_DIR) begin
          op = dir_op(t);
        end else begin
          op.rd = 1'($urandom_range(0, 1));
          op.wr = 1'($urandom_range(0, 1));
          if (!op.rd && !op.wr) op.rd = 1;
          op.off   = $urandom;
          op.wd    = $urandom;
          op.be    = 4'($urandom);
          op.abort = ($urandom_range(0, 7) == 0);
          do_rst   = !op.abort && ($urandom_range(0, 15) == 0);
          op.hold  = ($urandom_range(0, 3) == 0);
        end
        if (L == 1) begin
          op.abort = 0;
          do_rst   = 0;
        end

        if (!chained) @(negedge clk);
        n = chained ? cyc + 1 : cyc;
        chained = 0;
        bus.ren = op.rd; bus.wen = op.wr;
        bus.addr = BASE + op.off; bus.wdata = op.wd; bus.byte_en = op.be;
        idx = int'((op.off >> 2) % 32'd16);

        if (op.abort || do_rst) begin
          j = $urandom_range(1, L - 1);
          while (cyc < n + j) begin
            @(negedge clk);
            if (cyc > n) begin
              bus.addr = $urandom; bus.wdata = $urandom; bus.byte_en = 4'($urandom);
            end
          end
          bus.ren = 0; bus.wen = 0;
          if (op.abort) begin
            $display("inst%0d L=%0d abort after %0d wait cycles at cycle %0d", gi, L, j, cyc);
          end else begin
            rst_n = 1'b0;
            #1;
            n_cmp++;
            if (bus.busy !== 1'b1) begin
              n_bad++; $display("FAIL inst%0d midreset_busy: got %b required 1", gi, bus.busy);
            end
            n_cmp++;
            if (bus.rdata !== 32'h0) begin
              n_bad++; $display("FAIL inst%0d midreset_rdata: got %h required 0", gi, bus.rdata);
            end
            $display("inst%0d L=%0d reset after %0d wait cycles at cycle %0d", gi, L, j, cyc);
            @(negedge clk);
            rst_n = 1'b1;
            last_rd = 32'h0;
          end
        end else begin
          if (op.wr) begin
            mem[idx] = merge(mem[idx], op.wd, op.be);
            q.push_back('{n + L, last_rd, 1'b0});
          end else begin
            last_rd = mem[idx];
            q.push_back('{n + L, last_rd, 1'b1});
          end
          k = 0;
          do begin
            @(negedge clk);
            k++;
            if (bus.busy === 1'b1 && cyc > n) begin
              bus.addr = $urandom; bus.wdata = $urandom; bus.byte_en = 4'($urandom);
            end
          end while (bus.busy !== 1'b0 && k < 64);
          if (bus.busy !== 1'b0) begin
            n_cmp++; n_bad++;
            $display("FAIL inst%0d resp_timeout: busy %b after %0d cycles, required 0", gi, bus.busy, k);
          end
          bus.ren = 0; bus.wen = 0;
          if (op.hold) chained = 1;
        end
      end

      k = 0;
      while (q.size() != 0 && k < 100) begin
        @(negedge clk);
        k++;
      end
      n_cmp++;
      if (q.size() != 0) begin
        n_bad++;
        $display("FAIL inst%0d drain: %0d responses outstanding, required 0", gi, q.size());
      end
      done_cnt++;
    end
  end

  initial begin
    while (done_cnt < 4 && cyc < 80000) @(negedge clk);
    if (done_cnt < 4) begin
      n_cmp++; n_bad++;
      $display("FAIL global_timeout: %0d of 4 instances finished, required 4", done_cnt);
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
